// File: rtl/pwm_duty_ctrl.sv
// Closed-loop duty controller for the 3-bit PWM stage. It soft-starts the duty,
// applies hysteresis regulation with rate-limited steps, and trips to duty 0 on over-limit.
module pwm_duty_ctrl #(
  parameter int MEAS_W      = 12,
  parameter int STEP_CYCLES = 1000,
  parameter int START_DUTY  = 3,
  parameter int TRIP_LEVEL  = 4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              meas_valid,
  input  logic [MEAS_W-1:0] meas,
  input  logic [MEAS_W-1:0] setpoint,
  input  logic [MEAS_W-1:0] hyst,
  output logic              duty_inc,
  output logic              duty_dec,
  output logic              pwm_load,
  output logic [2:0]        duty_val,
  output logic [2:0]        duty_shadow,
  output logic [1:0]        state,
  output logic              fault
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]     RELOAD = TW'(STEP_CYCLES - 1);
  localparam logic [2:0]        START  = 3'(START_DUTY);
  localparam logic [MEAS_W-1:0] TRIP   = MEAS_W'(TRIP_LEVEL);
  localparam logic [MEAS_W:0]   MAXV   = {1'b0, {MEAS_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAMP     = 2'd1,
    REGULATE = 2'd2,
    FAULT    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    shadow_q, shadow_d;
  logic [2:0]    dval_q, dval_d;
  logic [TW-1:0] timer_q, timer_d, timer_dn;
  logic          up_q, up_d, dn_q, dn_d;
  logic          fault_q, fault_d;
  logic          inc_q, inc_d, dec_q, dec_d, load_q, load_d;

  logic [MEAS_W:0] lo, hi, sum;
  logic            trip, below, above, up_eff, dn_eff;

  // Band limits are formed one bit wider so the clamps at 0 and full scale cannot wrap.
  always_comb begin
    sum    = {1'b0, setpoint} + {1'b0, hyst};
    lo     = (setpoint >= hyst) ? {1'b0, setpoint - hyst} : '0;
    hi     = (sum > MAXV) ? MAXV : sum;
    below  = {1'b0, meas} < lo;
    above  = {1'b0, meas} > hi;
    trip   = meas_valid && (meas >= TRIP);
    up_eff = meas_valid ? below : up_q;
    dn_eff = meas_valid ? above : dn_q;
    timer_dn = (timer_q != '0) ? timer_q - 1'b1 : '0;
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    dval_d   = dval_q;
    timer_d  = timer_q;
    up_d     = up_q;
    dn_d     = dn_q;
    fault_d  = fault_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    load_d   = 1'b0;
    if (!en) begin
      state_d = IDLE;
      up_d    = 1'b0;
      dn_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          load_d   = 1'b1;
          dval_d   = '0;
          shadow_d = '0;
          timer_d  = RELOAD;
          fault_d  = 1'b0;
          state_d  = RAMP;
        end
        RAMP: begin
          if (trip) begin
            load_d = 1'b1; dval_d = '0; shadow_d = '0; fault_d = 1'b1;
            up_d = 1'b0; dn_d = 1'b0; state_d = FAULT;
          end else if (shadow_q == START) begin
            state_d = REGULATE;
            timer_d = timer_dn;
          end else if (timer_q == '0) begin
            inc_d    = 1'b1;
            shadow_d = shadow_q + 3'd1;
            timer_d  = RELOAD;
          end else begin
            timer_d = timer_dn;
          end
        end
        REGULATE: begin
          if (trip) begin
            load_d = 1'b1; dval_d = '0; shadow_d = '0; fault_d = 1'b1;
            up_d = 1'b0; dn_d = 1'b0; state_d = FAULT;
          end else begin
            up_d = up_eff;
            dn_d = dn_eff;
            // Decisions use this cycle's freshly classified flags for one-cycle latency.
            if (timer_q == '0 && up_eff && shadow_q != 3'd7) begin
              inc_d    = 1'b1;
              shadow_d = shadow_q + 3'd1;
              timer_d  = RELOAD;
            end else if (timer_q == '0 && dn_eff && shadow_q != 3'd0) begin
              dec_d    = 1'b1;
              shadow_d = shadow_q - 3'd1;
              timer_d  = RELOAD;
            end else begin
              timer_d = timer_dn;
            end
          end
        end
        FAULT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      dval_q   <= '0;
      timer_q  <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      fault_q  <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dval_q   <= dval_d;
      timer_q  <= timer_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      fault_q  <= fault_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      load_q   <= load_d;
    end
  end

  assign duty_inc    = inc_q;
  assign duty_dec    = dec_q;
  assign pwm_load    = load_q;
  assign duty_val    = dval_q;
  assign duty_shadow = shadow_q;
  assign state       = state_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed and randomized bench for pwm_duty_ctrl against an integer reference
// model of the controller's rules.
module tb_pwm_duty_ctrl;
  localparam int MW = 12;
  localparam int SC = 4;
  localparam int SD = 3;
  localparam int TL = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          meas_valid = 1'b0;
  logic [MW-1:0] meas = '0;
  logic [MW-1:0] setpoint = '0;
  logic [MW-1:0] hyst = '0;
  logic          duty_inc, duty_dec, pwm_load, fault;
  logic [2:0]    duty_val, duty_shadow;
  logic [1:0]    state;

  pwm_duty_ctrl #(.MEAS_W(MW), .STEP_CYCLES(SC), .START_DUTY(SD), .TRIP_LEVEL(TL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .meas_valid(meas_valid), .meas(meas),
    .setpoint(setpoint), .hyst(hyst), .duty_inc(duty_inc), .duty_dec(duty_dec),
    .pwm_load(pwm_load), .duty_val(duty_val), .duty_shadow(duty_shadow),
    .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  // model: mode 0 idle,1 ramp,2 regulate,3 fault
  int m_st, m_sh, m_tmr, m_up, m_dn, m_fault, m_inc, m_dec, m_ld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_sh = 0; m_tmr = 0; m_up = 0; m_dn = 0;
    m_fault = 0; m_inc = 0; m_dec = 0; m_ld = 0;
  endtask

  task automatic model_trip();
    m_ld = 1; m_sh = 0; m_fault = 1; m_st = 3; m_up = 0; m_dn = 0;
  endtask

  task automatic model_step();
    int lo, hi;
    logic tr;
    m_inc = 0; m_dec = 0; m_ld = 0;
    tr = meas_valid && (int'(meas) >= TL);
    if (!rst_n) model_reset();
    else if (!en) begin
      m_st = 0; m_up = 0; m_dn = 0;
    end else if (m_st == 0) begin
      m_ld = 1; m_sh = 0; m_tmr = SC - 1; m_fault = 0; m_st = 1;
    end else if (m_st == 1) begin
      if (tr) model_trip();
      else if (m_sh == SD) begin
        m_st = 2; if (m_tmr > 0) m_tmr--;
      end else if (m_tmr == 0) begin
        m_inc = 1; m_sh++; m_tmr = SC - 1;
      end else m_tmr--;
    end else if (m_st == 2) begin
      if (tr) model_trip();
      else begin
        if (meas_valid) begin
          lo = int'(setpoint) - int'(hyst); if (lo < 0) lo = 0;
          hi = int'(setpoint) + int'(hyst); if (hi > 4095) hi = 4095;
          m_up = (int'(meas) < lo) ? 1 : 0;
          m_dn = (int'(meas) > hi) ? 1 : 0;
        end
        if (m_tmr == 0 && m_up == 1 && m_sh < 7) begin
          m_inc = 1; m_sh++; m_tmr = SC - 1;
        end else if (m_tmr == 0 && m_dn == 1 && m_sh > 0) begin
          m_dec = 1; m_sh--; m_tmr = SC - 1;
        end else if (m_tmr > 0) m_tmr--;
      end
    end
  endtask

  task automatic check_all();
    chk("duty_inc", 32'(duty_inc), 32'(m_inc));
    chk("duty_dec", 32'(duty_dec), 32'(m_dec));
    chk("pwm_load", 32'(pwm_load), 32'(m_ld));
    chk("duty_val", 32'(duty_val), 32'd0);
    chk("duty_shadow", 32'(duty_shadow), 32'(m_sh));
    chk("state", 32'(state), 32'(m_st));
    chk("fault", 32'(fault), 32'(m_fault));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic strobe(input int sp, input int hy, input int m, input logic v);
    setpoint = MW'(sp); hyst = MW'(hy); meas = MW'(m); meas_valid = v;
  endtask

  initial begin
    int incs;
    model_reset();
    for (int i = 0; i < 3; i++) cyc();
    rst_n = 1'b1;
    cyc();

    // soft start from 0 up to START_DUTY
    en = 1'b1;
    incs = 0;
    for (int i = 0; i < 16; i++) begin cyc(); incs += m_inc; end
    chk("ramp_inc_count", 32'(incs), 32'd3);
    chk("ramp_end_state", 32'(state), 32'd2);
    chk("ramp_end_shadow", 32'(duty_shadow), 32'd3);

    // async reset mid-RAMP, then restart
    en = 1'b0; cyc(); en = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    #2 rst_n = 1'b1;
    cyc();
    chk("reload_after_reset", 32'(pwm_load), 32'd1);
    for (int i = 0; i < 16; i++) cyc();

    strobe(2000, 50, 1900, 1'b1);
    for (int i = 0; i < 30; i++) cyc();
    chk("sat_high_shadow", 32'(duty_shadow), 32'd7);
    strobe(2000, 50, 2030, 1'b1);
    for (int i = 0; i < 12; i++) cyc();
    strobe(2000, 50, 2100, 1'b1);
    for (int i = 0; i < 40; i++) cyc();
    chk("sat_low_shadow", 32'(duty_shadow), 32'd0);

    // lo clamps at 0: meas=0 is in band
    strobe(20, 50, 0, 1'b1);
    for (int i = 0; i < 12; i++) cyc();
    chk("lo_clamp_shadow", 32'(duty_shadow), 32'd0);

    strobe(2000, 50, 1900, 1'b1);
    for (int i = 0; i < 40 && m_sh != 4; i++) cyc();
    chk("raise_to_4", 32'(duty_shadow), 32'd4);
    // hi clamps at full scale: meas=3999 is in band
    strobe(3990, 200, 3999, 1'b1);
    for (int i = 0; i < 12; i++) cyc();
    chk("hi_clamp_shadow", 32'(duty_shadow), 32'd4);

    // set want_down, wait until a step is due, then trip
    strobe(2000, 50, 2100, 1'b1);
    cyc();
    meas_valid = 1'b0;
    for (int i = 0; i < 10 && m_tmr != 0; i++) cyc();
    strobe(2000, 50, 4000, 1'b1);
    cyc();
    chk("trip_load", 32'(pwm_load), 32'd1);
    chk("trip_fault", 32'(fault), 32'd1);
    chk("trip_no_dec", 32'(duty_dec), 32'd0);
    strobe(2000, 50, 100, 1'b1);
    for (int i = 0; i < 6; i++) cyc();
    en = 1'b0; cyc();
    chk("fault_sticky_idle", 32'(fault), 32'd1);
    en = 1'b1; cyc();
    chk("fault_clear_load", 32'(fault), 32'd0);

    // randomized regulation with occasional disables and trips
    setpoint = 12'd2000;
    for (int i = 0; i < 1500; i++) begin
      meas_valid = ($urandom_range(0, 3) != 0);
      meas = MW'(1800 + $urandom_range(0, 400));
      if ($urandom_range(0, 299) == 0) meas = MW'(4000 + $urandom_range(0, 95));
      en = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 99) == 0) hyst = MW'($urandom_range(0, 100));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
